// File: rtl/pu_params.sv
// Shared definitions for the PU layer sequencer: default field widths, the packed
// layer-config layout, FSM state codes and layer-type codes.
package pu_params;

    localparam int NUM_PE_DEF     = 8;
    localparam int MAX_LAYERS_DEF = 16;
    localparam int LPW            = 10;
    localparam int TIDW           = 16;
    localparam int PADW           = 3;
    localparam int STRW           = 3;
    localparam int LTW            = 2;

    // Field order is MSB first; oc/ic/ih/kh/kw hold (value - 1).
    typedef struct packed {
        logic [STRW-1:0] stride;
        logic [LPW-1:0]  pool_iw;
        logic [LPW-1:0]  pool_oh;
        logic [1:0]      pool_kernel;
        logic            pool;
        logic [LTW-1:0]  l_type;
        logic [TIDW-1:0] max_threads;
        logic [PADW-1:0] pad;
        logic [PADW-1:0] pad_row_start;
        logic [PADW-1:0] pad_row_end;
        logic            skip;
        logic [LPW-1:0]  endrow_iw;
        logic [LPW-1:0]  ic;
        logic [LPW-1:0]  ih;
        logic [LPW-1:0]  iw;
        logic [LPW-1:0]  oc;
        logic [LPW-1:0]  kh;
        logic [LPW-1:0]  kw;
    } layer_cfg_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_WAIT_PE = 3'd3;
    localparam logic [2:0] ST_POOL    = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;

    localparam logic [1:0] LT_CONV = 2'd0;
    localparam logic [1:0] LT_FC   = 2'd1;
    localparam logic [1:0] LT_NORM = 2'd2;

endpackage

// File: rtl/pu_cfg_table.sv
// Layer configuration register file: one write port, one registered read port.
// Left without reset so it maps onto block/distributed RAM.
module pu_cfg_table #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 124,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pu_layer_seq.sv
// Layer sequencer: walks every configured layer through output-group / input-channel
// passes, handshaking with vectorgen, the PE array and the pooling unit.
module pu_layer_seq
    import pu_params::*;
#(
    parameter int NUM_PE            = NUM_PE_DEF,
    parameter int MAX_LAYERS        = MAX_LAYERS_DEF,
    parameter int LAYER_PARAM_WIDTH = LPW,
    parameter int TID_WIDTH         = TIDW,
    parameter int PAD_WIDTH         = PADW,
    parameter int STRIDE_SIZE_W     = STRW,
    parameter int L_TYPE_WIDTH      = LTW,
    localparam int LAW      = $clog2(MAX_LAYERS),
    localparam int OFF_OC   = 2 * LAYER_PARAM_WIDTH,
    localparam int OFF_IC   = 5 * LAYER_PARAM_WIDTH,
    localparam int OFF_LT   = 7 * LAYER_PARAM_WIDTH + 1 + 3 * PAD_WIDTH + TID_WIDTH,
    localparam int OFF_POOL = OFF_LT + L_TYPE_WIDTH,
    localparam int CFG_W    = OFF_POOL + 3 + 2 * LAYER_PARAM_WIDTH + STRIDE_SIZE_W,
    localparam int OCB_W    = LAYER_PARAM_WIDTH + $clog2(NUM_PE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [LAW:0]                 num_layers,
    input  logic                         cfg_wr_en,
    input  logic [LAW-1:0]               cfg_wr_addr,
    input  logic [CFG_W-1:0]             cfg_wr_data,
    output logic                         rd_req,
    input  logic                         rd_ack,
    input  logic                         pe_done,
    input  logic                         pool_done,
    output logic [2:0]                   state,
    output logic [LAW-1:0]               layer_idx,
    output logic [CFG_W-1:0]             cfg_out,
    output logic [LAYER_PARAM_WIDTH-1:0] oc_idx,
    output logic [LAYER_PARAM_WIDTH-1:0] ic_idx,
    output logic [OCB_W-1:0]             oc_base,
    output logic                         first_ic,
    output logic                         last_ic,
    output logic                         pool_start,
    output logic                         busy,
    output logic                         done
);

    logic [2:0]                   state_q, state_d;
    logic [LAW-1:0]               layer_idx_q, layer_idx_d;
    logic [LAW:0]                 num_layers_q, num_layers_d;
    logic [CFG_W-1:0]             cfg_q, cfg_d;
    logic [LAYER_PARAM_WIDTH-1:0] oc_idx_q, oc_idx_d;
    logic [LAYER_PARAM_WIDTH-1:0] ic_idx_q, ic_idx_d;
    logic                         pool_start_q, pool_start_d;
    logic                         done_q, done_d;
    logic                         busy_q;
    logic                         grp_end, grp_adv;
    logic [CFG_W-1:0]             tbl_rd_data;

    logic [LAYER_PARAM_WIDTH-1:0] oc_lim, ic_lim;
    logic [L_TYPE_WIDTH-1:0]      l_type;
    logic                         pool_en, single_pass;

    assign oc_lim      = cfg_q[OFF_OC +: LAYER_PARAM_WIDTH];
    assign ic_lim      = cfg_q[OFF_IC +: LAYER_PARAM_WIDTH];
    assign l_type      = cfg_q[OFF_LT +: L_TYPE_WIDTH];
    assign pool_en     = cfg_q[OFF_POOL];
    assign single_pass = (l_type == LT_FC) || (l_type == LT_NORM);

    // Read address follows the next layer index so the word is ready during LOAD.
    pu_cfg_table #(
        .DEPTH (MAX_LAYERS),
        .WIDTH (CFG_W)
    ) u_cfg_table (
        .clk       (clk),
        .wr_en_i   (cfg_wr_en && (state_q == ST_IDLE)),
        .wr_addr_i (cfg_wr_addr),
        .wr_data_i (cfg_wr_data),
        .rd_addr_i (layer_idx_d),
        .rd_data_o (tbl_rd_data)
    );

    always_comb begin
        state_d      = state_q;
        layer_idx_d  = layer_idx_q;
        num_layers_d = num_layers_q;
        cfg_d        = cfg_q;
        oc_idx_d     = oc_idx_q;
        ic_idx_d     = ic_idx_q;
        pool_start_d = 1'b0;
        done_d       = 1'b0;
        grp_end      = 1'b0;
        grp_adv      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_layers != '0) begin
                        state_d      = ST_LOAD;
                        layer_idx_d  = '0;
                        num_layers_d = num_layers;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                cfg_d    = tbl_rd_data;
                oc_idx_d = '0;
                ic_idx_d = '0;
                state_d  = ST_REQ;
            end
            ST_REQ: begin
                if (rd_ack) begin
                    state_d = ST_WAIT_PE;
                end
            end
            ST_WAIT_PE: begin
                if (pe_done) begin
                    if (l_type == LT_FC) begin
                        grp_end = 1'b1;
                    end else if (ic_idx_q < ic_lim) begin
                        ic_idx_d = ic_idx_q + 1'b1;
                        state_d  = ST_REQ;
                    end else begin
                        ic_idx_d = '0;
                        grp_end  = 1'b1;
                    end
                end
            end
            ST_POOL: begin
                if (pool_done) begin
                    grp_adv = 1'b1;
                end
            end
            ST_NEXT: begin
                if (({1'b0, layer_idx_q} + 1'b1) < num_layers_q) begin
                    layer_idx_d = layer_idx_q + 1'b1;
                    state_d     = ST_LOAD;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grp_end) begin
            if (pool_en) begin
                state_d      = ST_POOL;
                pool_start_d = 1'b1;
            end else begin
                grp_adv = 1'b1;
            end
        end

        // Norm layers are a single output group regardless of the stored oc.
        if (grp_adv) begin
            if ((l_type != LT_NORM) && (oc_idx_q < oc_lim)) begin
                oc_idx_d = oc_idx_q + 1'b1;
                state_d  = ST_REQ;
            end else begin
                state_d = ST_NEXT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            layer_idx_q  <= '0;
            num_layers_q <= '0;
            cfg_q        <= '0;
            oc_idx_q     <= '0;
            ic_idx_q     <= '0;
            pool_start_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_idx_q  <= layer_idx_d;
            num_layers_q <= num_layers_d;
            cfg_q        <= cfg_d;
            oc_idx_q     <= oc_idx_d;
            ic_idx_q     <= ic_idx_d;
            pool_start_q <= pool_start_d;
            done_q       <= done_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign state      = state_q;
    assign layer_idx  = layer_idx_q;
    assign cfg_out    = cfg_q;
    assign oc_idx     = oc_idx_q;
    assign ic_idx     = ic_idx_q;
    assign oc_base    = OCB_W'(oc_idx_q) * OCB_W'(NUM_PE);
    assign rd_req     = (state_q == ST_REQ);
    assign first_ic   = single_pass || (ic_idx_q == '0);
    assign last_ic    = single_pass || (ic_idx_q == ic_lim);
    assign pool_start = pool_start_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pu_layer_seq.sv
// Directed bench for pu_layer_seq: a small responder acts as vectorgen, PE array
// and pooling unit while per-request observations are collected and checked.
module tb_pu_layer_seq;
    import pu_params::*;

    localparam int CW = $bits(layer_cfg_t);

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [4:0]     num_layers = '0;
    logic           cfg_wr_en = 1'b0;
    logic [3:0]     cfg_wr_addr = '0;
    logic [CW-1:0]  cfg_wr_data = '0;
    logic           rd_ack = 1'b0;
    logic           pe_done = 1'b0;
    logic           pool_done = 1'b0;

    logic           rd_req;
    logic [2:0]     state;
    logic [3:0]     layer_idx;
    logic [CW-1:0]  cfg_out;
    logic [9:0]     oc_idx, ic_idx;
    logic [12:0]    oc_base;
    logic           first_ic, last_ic, pool_start, busy, done;

    pu_layer_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_layers  (num_layers),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_wr_data (cfg_wr_data),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .pe_done     (pe_done),
        .pool_done   (pool_done),
        .state       (state),
        .layer_idx   (layer_idx),
        .cfg_out     (cfg_out),
        .oc_idx      (oc_idx),
        .ic_idx      (ic_idx),
        .oc_base     (oc_base),
        .first_ic    (first_ic),
        .last_ic     (last_ic),
        .pool_start  (pool_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    int            n_req, n_done, n_pool, early_req, done_cyc, first_req_cyc, gap01, req_cyc_prev;
    logic [31:0]   ic_seq, oc_seq, ly_seq, first_mask, last_mask;
    logic [CW-1:0] cfg_at_first;
    logic [12:0]   last_oc_base;
    logic          busy_at_done, busy_at_req;
    layer_cfg_t    poke_word;
    layer_cfg_t    w0, w1, w2;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic layer_cfg_t mk_cfg(input logic [1:0] lt, input logic pool,
                                          input logic [9:0] oc_m1, input logic [9:0] ic_m1);
        layer_cfg_t c;
        c             = '0;
        c.l_type      = lt;
        c.pool        = pool;
        c.oc          = oc_m1;
        c.ic          = ic_m1;
        c.kw          = 10'd2;
        c.kh          = 10'd2;
        c.max_threads = 16'd100;
        c.stride      = 3'd1;
        return c;
    endfunction

    // Called right after a falling edge; returns right after a falling edge.
    task automatic wr_cfg(input logic [3:0] a, input layer_cfg_t w);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = w;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic run_seq(input logic [4:0] nl, input bit poke);
        int pe_cnt;
        int pool_cnt;
        pe_cnt = 0; pool_cnt = 0;
        n_req = 0; n_done = 0; n_pool = 0; early_req = 0;
        done_cyc = -1; first_req_cyc = -1; gap01 = -1; req_cyc_prev = 0;
        ic_seq = '0; oc_seq = '0; ly_seq = '0; first_mask = '0; last_mask = '0;
        cfg_at_first = '0; last_oc_base = '0; busy_at_done = 1'bx; busy_at_req = 1'bx;
        start = 1'b1;
        num_layers = nl;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (n_done > 0 && c > done_cyc + 3) break;
            rd_ack = 1'b0; pe_done = 1'b0; pool_done = 1'b0;
            if (poke && c == 1) begin
                start = 1'b1; num_layers = 5'd3;
                cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_data = poke_word;
            end else if (poke && c == 2) begin
                start = 1'b0; cfg_wr_en = 1'b0;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    done_cyc = c;
                    busy_at_done = busy;
                end
            end
            if (pool_start) begin
                n_pool++;
                pool_cnt = 4;
            end
            if (rd_req && pool_cnt > 0) early_req++;
            if (pool_cnt > 0) begin
                pool_cnt--;
                if (pool_cnt == 0) pool_done = 1'b1;
            end
            if (pe_cnt > 0) begin
                pe_cnt--;
                if (pe_cnt == 0) pe_done = 1'b1;
            end
            if (rd_req) begin
                if (n_req == 0) begin
                    first_req_cyc = c;
                    cfg_at_first  = cfg_out;
                    busy_at_req   = busy;
                end
                if (n_req == 1) gap01 = c - req_cyc_prev;
                req_cyc_prev = c;
                ic_seq       = (ic_seq << 4) | 32'(ic_idx[3:0]);
                oc_seq       = (oc_seq << 4) | 32'(oc_idx[3:0]);
                ly_seq       = (ly_seq << 4) | 32'(layer_idx);
                first_mask   = (first_mask << 1) | 32'(first_ic);
                last_mask    = (last_mask << 1) | 32'(last_ic);
                last_oc_base = oc_base;
                $display("req %0d: layer=%0d oc=%0d ic=%0d first=%0b last=%0b",
                         n_req, layer_idx, oc_idx, ic_idx, first_ic, last_ic);
                rd_ack = 1'b1;
                pe_cnt = 2;
                n_req++;
            end
            @(negedge clk);
        end
        start = 1'b0; cfg_wr_en = 1'b0;
        rd_ack = 1'b0; pe_done = 1'b0; pool_done = 1'b0;
    endtask

    initial begin
        bit seen;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_state", state, ST_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_out", cfg_out, 0);
        chk("rst_layer_idx", layer_idx, 0);

        // conv: 2 output groups x 3 input channels
        w0 = mk_cfg(LT_CONV, 1'b0, 10'd1, 10'd2);
        wr_cfg(4'd0, w0);
        run_seq(5'd1, 1'b0);
        chk("conv_nreq", n_req, 6);
        chk("conv_first_req_cyc", first_req_cyc, 1);
        chk("conv_gap", gap01, 3);
        chk("conv_ic_seq", ic_seq, 32'h012012);
        chk("conv_oc_seq", oc_seq, 32'h000111);
        chk("conv_first_mask", first_mask, 6'b100100);
        chk("conv_last_mask", last_mask, 6'b001001);
        chk("conv_cfg_out", cfg_at_first, w0);
        chk("conv_oc_base", last_oc_base, 8);
        chk("conv_busy_req", busy_at_req, 1);
        chk("conv_ndone", n_done, 1);
        chk("conv_npool", n_pool, 0);

        // FC: 4 groups, single pass each
        wr_cfg(4'd0, mk_cfg(LT_FC, 1'b0, 10'd3, 10'd5));
        run_seq(5'd1, 1'b0);
        chk("fc_nreq", n_req, 4);
        chk("fc_ic_seq", ic_seq, 0);
        chk("fc_oc_seq", oc_seq, 32'h0123);
        chk("fc_first_mask", first_mask, 4'hF);
        chk("fc_last_mask", last_mask, 4'hF);
        chk("fc_oc_base", last_oc_base, 24);
        chk("fc_ndone", n_done, 1);

        // conv with pooling after each of 2 groups
        wr_cfg(4'd0, mk_cfg(LT_CONV, 1'b1, 10'd1, 10'd0));
        run_seq(5'd1, 1'b0);
        chk("pool_nreq", n_req, 2);
        chk("pool_npool", n_pool, 2);
        chk("pool_early_req", early_req, 0);
        chk("pool_oc_seq", oc_seq, 32'h01);
        chk("pool_ndone", n_done, 1);

        // three layers: conv(1 group, 2 ic), norm(4 ic, stored oc ignored), FC(1 group)
        w0 = mk_cfg(LT_CONV, 1'b0, 10'd0, 10'd1);
        w1 = mk_cfg(LT_NORM, 1'b0, 10'd5, 10'd3);
        w2 = mk_cfg(LT_FC, 1'b0, 10'd0, 10'd0);
        wr_cfg(4'd0, w0);
        wr_cfg(4'd1, w1);
        wr_cfg(4'd2, w2);
        run_seq(5'd3, 1'b0);
        chk("ml_nreq", n_req, 7);
        chk("ml_layer_seq", ly_seq, 32'h0011112);
        chk("ml_ic_seq", ic_seq, 32'h0101230);
        chk("ml_oc_seq", oc_seq, 0);
        chk("ml_first_mask", first_mask, 7'b1011111);
        chk("ml_last_mask", last_mask, 7'b0111111);
        chk("ml_ndone", n_done, 1);
        chk("ml_busy_at_done", busy_at_done, 0);

        // zero layers: immediate done, no requests
        run_seq(5'd0, 1'b0);
        chk("zero_done_cyc", done_cyc, 0);
        chk("zero_ndone", n_done, 1);
        chk("zero_nreq", n_req, 0);

        // start and table write while busy are ignored
        w0 = mk_cfg(LT_FC, 1'b0, 10'd0, 10'd0);
        poke_word = mk_cfg(LT_CONV, 1'b1, 10'd3, 10'd3);
        wr_cfg(4'd0, w0);
        run_seq(5'd1, 1'b1);
        chk("busy_poke_nreq", n_req, 1);
        chk("busy_poke_ndone", n_done, 1);
        chk("busy_poke_cfg", cfg_at_first, w0);
        run_seq(5'd1, 1'b0);
        chk("table_kept_nreq", n_req, 1);
        chk("table_kept_cfg", cfg_at_first, w0);

        // asynchronous reset while waiting on the PE
        w0 = mk_cfg(LT_CONV, 1'b0, 10'd0, 10'd2);
        wr_cfg(4'd0, w0);
        start = 1'b1; num_layers = 5'd1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (rd_req) seen = 1'b1;
            else @(negedge clk);
        end
        chk("arst_req_seen", seen, 1);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        chk("arst_pre_state", state, ST_WAIT_PE);
        #2 reset = 1'b0;
        #1;
        chk("arst_state", state, ST_IDLE);
        chk("arst_rd_req", rd_req, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_cfg(4'd0, w0);
        run_seq(5'd1, 1'b0);
        chk("arst_rerun_nreq", n_req, 3);
        chk("arst_rerun_ic_seq", ic_seq, 32'h012);
        chk("arst_rerun_ndone", n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
